sccb_cfg_sequencer: RTL and testbench

SCCB_CFG_SEQUENCER -- requirements
Module: sccb_cfg_sequencer

---
 rtl/sccb_cfg_pkg.sv | 45 ++++
 rtl/sccb_init_rom.sv | 33 +++
 rtl/sccb_cfg_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sccb_cfg_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_cfg_pkg.sv
// Shared encodings for the SCCB init sequencer: table entry layout, FSM states, bridge command/response codes.
// The RD_* states only exist when SCCB_CFG_VERIFY_EN is defined.
package sccb_cfg_pkg;

    localparam int OP_W    = 2;
    localparam int REG_W   = 8;
    localparam int VAL_W   = 8;
    localparam int ENTRY_W = OP_W + REG_W + VAL_W;
    localparam int DLY_W   = 24;

    typedef enum logic [OP_W-1:0] {
        OP_WRITE = 2'b00,
        OP_DELAY = 2'b01,
        OP_RSVD  = 2'b10,
        OP_END   = 2'b11
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [REG_W-1:0] ra;
        logic [VAL_W-1:0] val;
    } entry_t;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [1:0] RESP_DVA = 2'b01;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_WR_REQ  = 4'd3,
        ST_WR_WAIT = 4'd4,
        ST_DLY     = 4'd5,
        ST_DONE    = 4'd6
`ifdef SCCB_CFG_VERIFY_EN
        ,
        ST_RD_REQ  = 4'd7,
        ST_RD_RSP  = 4'd8,
        ST_RD_WAIT = 4'd9
`endif
    } state_e;

endpackage

// File: rtl/sccb_init_rom.sv
// Camera init table with one cycle of registered read latency.
// Camera variants replace only this file; unlisted addresses read as END.
module sccb_init_rom
    import sccb_cfg_pkg::*;
#(
    parameter int ROM_AW = 6
) (
    input  logic               sccb_clk,
    input  logic               sccb_reset_n,
    input  logic [ROM_AW-1:0]  addr,
    output logic [ENTRY_W-1:0] entry
);

    logic [ENTRY_W-1:0] entry_d, entry_q;

    always_comb begin
        entry_d = {OP_END, 8'h00, 8'h00};
        case (32'(addr))
            0:       entry_d = {OP_WRITE, 8'h12, 8'h80};
            1:       entry_d = {OP_DELAY, 8'h00, 8'h03};
            2:       entry_d = {OP_WRITE, 8'h11, 8'h01};
            default: entry_d = {OP_END,   8'h00, 8'h00};
        endcase
    end

    always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
        if (!sccb_reset_n) entry_q <= '0;
        else               entry_q <= entry_d;
    end

    assign entry = entry_q;

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks the init table, issuing SCCB register writes and delays, then hands the bridge to the host.
// Define SCCB_CFG_VERIFY_EN to read back every write and flag mismatches on init_err.
module sccb_cfg_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ID   = 7'h21,
    parameter int          ROM_AW     = 6,
    parameter logic [15:0] DELAY_UNIT = 16'd1000
) (
    input  logic              sccb_clk,
    input  logic              sccb_reset_n,
    input  logic              start,
    output logic [2:0]        mcmd,
    output logic [14:0]       maddr,
    output logic [7:0]        mdata,
    input  logic              scmdaccept,
    input  logic [1:0]        sresp,
    input  logic [7:0]        sdata,
    input  logic [2:0]        h_mcmd,
    input  logic [14:0]       h_maddr,
    input  logic [7:0]        h_mdata,
    output logic              h_scmdaccept,
    output logic [1:0]        h_sresp,
    output logic [7:0]        h_sdata,
    output logic              init_busy,
    output logic              init_done,
    output logic              init_err,
    output logic [ROM_AW-1:0] step
);

    state_e             state_q, state_d, adv_state;
    logic [ROM_AW-1:0]  step_q, step_d, adv_step;
    logic [14:0]        maddr_q, maddr_d;
    logic [7:0]         mdata_q, mdata_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic               pend_q, pend_d;
    logic [ENTRY_W-1:0] rom_entry;
    entry_t             entry;
    logic               last_step, host_quiet, restart;

    sccb_init_rom #(.ROM_AW(ROM_AW)) u_rom (
        .sccb_clk     (sccb_clk),
        .sccb_reset_n (sccb_reset_n),
        .addr         (step_q),
        .entry        (rom_entry)
    );

    assign entry      = entry_t'(rom_entry);
    // The last table slot terminates the run even without an END entry.
    assign last_step  = (step_q == {ROM_AW{1'b1}});
    assign adv_state  = last_step ? ST_DONE : ST_FETCH;
    assign adv_step   = last_step ? step_q : step_q + 1'b1;
    assign host_quiet = (h_mcmd == CMD_IDLE) && scmdaccept;
    assign restart    = ((state_q == ST_IDLE) && start) ||
                        ((state_q == ST_DONE) && (start || pend_q) && host_quiet);

    always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
        if (!sccb_reset_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            maddr_q <= '0;
            mdata_q <= '0;
            dly_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            dly_q   <= dly_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        dly_d   = dly_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (restart) begin
                    state_d = ST_FETCH;
                    step_d  = '0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (entry.op)
                    OP_WRITE: begin
                        state_d = ST_WR_REQ;
                        maddr_d = {SLAVE_ID, entry.ra};
                        mdata_d = entry.val;
                    end
                    OP_DELAY: begin
                        state_d = ST_DLY;
                        dly_d   = DLY_W'(entry.val) * DLY_W'(DELAY_UNIT);
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_WR_REQ: if (sresp == RESP_DVA) state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (scmdaccept) begin
`ifdef SCCB_CFG_VERIFY_EN
                    state_d = ST_RD_REQ;
`else
                    state_d = adv_state;
                    step_d  = adv_step;
`endif
                end
            end
            // A zero count still spends one cycle here.
            ST_DLY: begin
                if (dly_q <= DLY_W'(1)) begin
                    state_d = adv_state;
                    step_d  = adv_step;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_d = ST_FETCH;
                    step_d  = '0;
                    pend_d  = 1'b0;
                end else if (start) begin
                    pend_d = 1'b1;
                end
            end
`ifdef SCCB_CFG_VERIFY_EN
            ST_RD_REQ:  if (!scmdaccept) state_d = ST_RD_RSP;
            ST_RD_RSP:  if (sresp == RESP_DVA) state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (scmdaccept) begin
                    state_d = adv_state;
                    step_d  = adv_step;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // mcmd is decoded from state so an async reset drops it at once.
    always_comb begin
        mcmd         = CMD_IDLE;
        maddr        = maddr_q;
        mdata        = mdata_q;
        h_scmdaccept = 1'b0;
        h_sresp      = 2'b00;
        h_sdata      = 8'h00;
        init_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
        init_done    = (state_q == ST_DONE);
        case (state_q)
            ST_WR_REQ: mcmd = (sresp == RESP_DVA) ? CMD_IDLE : CMD_WR;
`ifdef SCCB_CFG_VERIFY_EN
            ST_RD_REQ: mcmd = scmdaccept ? CMD_RD : CMD_IDLE;
`endif
            ST_DONE: begin
                mcmd         = h_mcmd;
                maddr        = h_maddr;
                mdata        = h_mdata;
                h_scmdaccept = scmdaccept;
                h_sresp      = sresp;
                h_sdata      = sdata;
            end
            default: ;
        endcase
    end

    assign step = step_q;

`ifdef SCCB_CFG_VERIFY_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (restart)
            err_d = 1'b0;
        else if ((state_q == ST_RD_RSP) && (sresp == RESP_DVA) && (sdata != mdata_q))
            err_d = 1'b1;
    end

    always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
        if (!sccb_reset_n) err_q <= 1'b0;
        else               err_q <= err_d;
    end

    assign init_err = err_q;
`else
    assign init_err = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench: two sequencers (64-entry and 2-entry tables, DELAY_UNIT=10) each driving a small bridge model.
// The 2-entry instance has no END in range, so it exercises the last-slot termination.
module tb_sccb_cfg_sequencer;

    localparam int NDUT = 2;
    localparam int DIV  = 4;
`ifdef SCCB_CFG_VERIFY_EN
    localparam int EXP_ERR = 1;
    localparam int EXP_RD  = 2;
    localparam int W2      = 2;
`else
    localparam int EXP_ERR = 0;
    localparam int EXP_RD  = 0;
    localparam int W2      = 1;
`endif

    logic        sccb_clk = 1'b0;
    logic        sccb_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  h_mcmd = 3'b000;
    logic [14:0] h_maddr = 15'h0;
    logic [7:0]  h_mdata = 8'h0;

    logic [2:0]  log_cmd[$];
    logic [14:0] log_addr[$];
    logic [7:0]  log_data[$];
    int          log_gap[$];

    logic [15:0] trace = 16'h0;
    logic [5:0]  prev_step = 6'h3F;

    int n_chk = 0;
    int n_err = 0;

    always #5 sccb_clk = ~sccb_clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_inst
        localparam int RAW = (g == 0) ? 6 : 1;
        logic [2:0]     mcmd;
        logic [14:0]    maddr;
        logic [7:0]     mdata;
        logic           scmdaccept;
        logic [1:0]     sresp;
        logic [7:0]     sdata;
        logic           h_scmdaccept;
        logic [1:0]     h_sresp;
        logic [7:0]     h_sdata;
        logic           init_busy, init_done, init_err;
        logic [RAW-1:0] step;
        int             wr_cnt, rd_cnt, cnt;
        logic [7:0]     mem [256];
        logic [14:0]    cur_addr;
        time            t_idle;

        sccb_cfg_sequencer #(.SLAVE_ID(7'h21), .ROM_AW(RAW), .DELAY_UNIT(16'd10)) dut (
            .sccb_clk     (sccb_clk),
            .sccb_reset_n (sccb_reset_n),
            .start        (start),
            .mcmd         (mcmd),
            .maddr        (maddr),
            .mdata        (mdata),
            .scmdaccept   (scmdaccept),
            .sresp        (sresp),
            .sdata        (sdata),
            .h_mcmd       (h_mcmd),
            .h_maddr      (h_maddr),
            .h_mdata      (h_mdata),
            .h_scmdaccept (h_scmdaccept),
            .h_sresp      (h_sresp),
            .h_sdata      (h_sdata),
            .init_busy    (init_busy),
            .init_done    (init_done),
            .init_err     (init_err),
            .step         (step)
        );

        // Bridge: accepts when idle, DVA 8 cycles later, idle again 12 cycles after accept.
        // Reg 0x12 reads back 0x7F, reg 0x0A reads 0x76, others return what was written.
        always @(posedge sccb_clk or negedge sccb_reset_n) begin
            if (!sccb_reset_n) begin
                scmdaccept <= 1'b1;
                sresp      <= 2'b00;
                sdata      <= 8'h00;
                cnt        <= 0;
                wr_cnt     <= 0;
                rd_cnt     <= 0;
                cur_addr   <= 15'h0;
                t_idle     <= 0;
            end else begin
                sresp <= 2'b00;
                if (scmdaccept && mcmd != 3'b000) begin
                    scmdaccept <= 1'b0;
                    cnt        <= 3 * DIV;
                    cur_addr   <= maddr;
                    if (mcmd == 3'b001) begin
                        mem[maddr[7:0]] <= mdata;
                        wr_cnt <= wr_cnt + 1;
                    end else begin
                        rd_cnt <= rd_cnt + 1;
                    end
                end else if (!scmdaccept) begin
                    cnt <= cnt - 1;
                    if (cnt == DIV + 1) begin
                        sresp <= 2'b01;
                        sdata <= (cur_addr[7:0] == 8'h12) ? 8'h7F :
                                 (cur_addr[7:0] == 8'h0A) ? 8'h76 : mem[cur_addr[7:0]];
                    end
                    if (cnt == 1) begin
                        scmdaccept <= 1'b1;
                        t_idle     <= $time;
                    end
                end
            end
        end

        if (g == 0) begin : g_log
            always @(posedge sccb_clk) begin
                if (sccb_reset_n && scmdaccept && mcmd != 3'b000) begin
                    log_cmd.push_back(mcmd);
                    log_addr.push_back(maddr);
                    log_data.push_back(mdata);
                    log_gap.push_back(int'(($time - t_idle) / 10));
                end
            end
        end
    end

    // Step trace of instance 0: one nibble per distinct step while busy, cleared by start.
    always @(negedge sccb_clk) begin
        if (start) begin
            trace     <= 16'h0;
            prev_step <= 6'h3F;
        end else if (g_inst[0].init_busy && g_inst[0].step != prev_step) begin
            trace     <= {trace[11:0], g_inst[0].step[3:0]};
            prev_step <= g_inst[0].step;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge sccb_clk);
        #1 start = 1'b1;
        @(posedge sccb_clk);
        #1 start = 1'b0;
    endtask

    initial begin
        logic bad;

        // Reset values
        #12;
        chk("rst_mcmd",  32'(g_inst[0].mcmd), 32'h0);
        chk("rst_maddr", 32'(g_inst[0].maddr), 32'h0);
        chk("rst_mdata", 32'(g_inst[0].mdata), 32'h0);
        chk("rst_step",  32'(g_inst[0].step), 32'h0);
        chk("rst_busy",  32'(g_inst[0].init_busy), 32'h0);
        chk("rst_done",  32'(g_inst[0].init_done), 32'h0);
        chk("rst_err",   32'(g_inst[0].init_err), 32'h0);
        chk("rst_hacc",  32'(g_inst[0].h_scmdaccept), 32'h0);
        chk("rst_hresp", 32'(g_inst[0].h_sresp), 32'h0);
        chk("rst_hdata", 32'(g_inst[0].h_sdata), 32'h0);
        @(posedge sccb_clk);
        #1 sccb_reset_n = 1'b1;
        repeat (5) @(negedge sccb_clk);
        chk("idle_no_run", 32'(g_inst[0].init_busy), 32'h0);

        // Init run
        pulse_start();
        @(negedge sccb_clk);
        chk("start_busy", 32'(g_inst[0].init_busy), 32'h1);
        chk("start_step", 32'(g_inst[0].step), 32'h0);

        // Host read during init must be blocked
        for (int i = 0; i < 200 && g_inst[0].step != 6'd1; i++) @(negedge sccb_clk);
        chk("reach_step1", 32'(g_inst[0].step), 32'h1);
        h_mcmd = 3'b010;
        h_maddr = 15'h210A;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sccb_clk);
            if (g_inst[0].h_scmdaccept !== 1'b0 || g_inst[0].mcmd !== 3'b000) bad = 1'b1;
        end
        chk("host_blocked", 32'(bad), 32'h0);
        h_mcmd = 3'b000;

        for (int i = 0; i < 1000 && !g_inst[0].init_done; i++) @(negedge sccb_clk);
        chk("done",       32'(g_inst[0].init_done), 32'h1);
        chk("done_busy",  32'(g_inst[0].init_busy), 32'h0);
        chk("done_step",  32'(g_inst[0].step), 32'h3);
        chk("done_err",   32'(g_inst[0].init_err), 32'(EXP_ERR));
        chk("wr_cnt",     32'(g_inst[0].wr_cnt), 32'h2);
        chk("rd_cnt",     32'(g_inst[0].rd_cnt), 32'(EXP_RD));
        chk("log_size",   32'(log_cmd.size()), 32'(2 + EXP_RD));
        chk("wr0_cmd",    32'(log_cmd[0]), 32'h1);
        chk("wr0_addr",   32'(log_addr[0]), 32'h2112);
        chk("wr0_data",   32'(log_data[0]), 32'h80);
        chk("wr1_addr",   32'(log_addr[W2]), 32'h2111);
        chk("wr1_data",   32'(log_data[W2]), 32'h01);
        // 30 delay cycles + WR_WAIT/RD_WAIT, FETCH, DECODE, FETCH, DECODE, WR_REQ-to-accept edge
        chk("dly_gap",    32'(log_gap[W2]), 32'd36);
        chk("step_trace", 32'(trace), 32'h0123);
        chk("short_done", 32'(g_inst[1].init_done), 32'h1);
        chk("short_step", 32'(g_inst[1].step), 32'h1);
        chk("short_wr",   32'(g_inst[1].wr_cnt), 32'h1);
        chk("short_err",  32'(g_inst[1].init_err), 32'(EXP_ERR));

        // Host read through the bridge in DONE
        @(negedge sccb_clk);
        h_mcmd = 3'b010;
        h_maddr = 15'h210A;
        #1;
        chk("host_mcmd", 32'(g_inst[0].mcmd), 32'h2);
        chk("host_acc",  32'(g_inst[0].h_scmdaccept), 32'h1);
        @(posedge sccb_clk);
        #1 h_mcmd = 3'b000;
        for (int i = 0; i < 40 && g_inst[0].h_sresp != 2'b01; i++) @(negedge sccb_clk);
        chk("host_resp",  32'(g_inst[0].h_sresp), 32'h1);
        chk("host_sdata", 32'(g_inst[0].h_sdata), 32'h76);
        for (int i = 0; i < 40 && !g_inst[0].h_scmdaccept; i++) @(negedge sccb_clk);

        // Start while the host owns the bridge is held pending
        @(posedge sccb_clk);
        #1 begin h_mcmd = 3'b001; h_maddr = 15'h2150; h_mdata = 8'h00; start = 1'b1; end
        @(posedge sccb_clk);
        #1 begin h_mcmd = 3'b000; start = 1'b0; end
        repeat (3) @(negedge sccb_clk);
        chk("pend_held", 32'(g_inst[0].init_done), 32'h1);
        for (int i = 0; i < 40 && !g_inst[0].init_busy; i++) @(negedge sccb_clk);
        chk("pend_busy", 32'(g_inst[0].init_busy), 32'h1);
        chk("pend_step", 32'(g_inst[0].step), 32'h0);
        chk("pend_err",  32'(g_inst[0].init_err), 32'h0);

        // Reset in the middle of WR_REQ
        for (int i = 0; i < 20 && g_inst[0].mcmd != 3'b001; i++) @(negedge sccb_clk);
        chk("mid_wrreq", 32'(g_inst[0].mcmd), 32'h1);
        #2 sccb_reset_n = 1'b0;
        #1;
        chk("mid_rst_mcmd",  32'(g_inst[0].mcmd), 32'h0);
        chk("mid_rst_maddr", 32'(g_inst[0].maddr), 32'h0);
        chk("mid_rst_mdata", 32'(g_inst[0].mdata), 32'h0);
        chk("mid_rst_busy",  32'(g_inst[0].init_busy), 32'h0);
        chk("mid_rst_step",  32'(g_inst[0].step), 32'h0);
        log_cmd.delete();
        log_addr.delete();
        log_data.delete();
        log_gap.delete();
        repeat (2) @(posedge sccb_clk);
        #1 sccb_reset_n = 1'b1;
        repeat (5) @(negedge sccb_clk);
        chk("post_rst_idle", 32'(g_inst[0].init_busy), 32'h0);
        chk("post_rst_nowr", 32'(g_inst[0].wr_cnt), 32'h0);

        // Replay from step 0
        pulse_start();
        for (int i = 0; i < 1000 && !g_inst[0].init_done; i++) @(negedge sccb_clk);
        chk("replay_done",  32'(g_inst[0].init_done), 32'h1);
        chk("replay_wr",    32'(g_inst[0].wr_cnt), 32'h2);
        chk("replay_addr0", 32'(log_addr[0]), 32'h2112);
        chk("replay_trace", 32'(trace), 32'h0123);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
